rpc2_ctrl_fifo_wr_ctrl: RTL and testbench
=========================================

// Module: rpc2_ctrl_fifo_wr_ctrl
// PURPOSE
//  Write-side pointer/flag controller for the controller's async FIFOs. Accepts push
//  requests, advances a binary+Gray write pointer, drives RAM write enable/address,
//  and synchronizes the read-domain Gray pointer to compute full, almost_full and
//  free count. One instance per FIFO write port; read side is a separate block.
// PARAMETERS
//  ADDR_WIDTH   8  RAM address width; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
//  AFULL_THRESH 4  almost_full asserted when free_cnt <= AFULL_THRESH
//  SYNC_STAGES  2  flop stages synchronizing rd_gray_ptr into clk domain (>=2)
// PORTS
//  clk          in   1             write-domain clock
//  rst_n        in   1             reset, asynchronous, active-low
//  wr_req       in   1             push request (data presented to RAM externally)
//  wr_ready     out  1             ~full; push accepted when wr_req & wr_ready
//  wr_en        out  1             RAM write strobe = wr_req & ~full (combinational)
//  wr_addr      out  ADDR_WIDTH    RAM write address = wr_bin[ADDR_WIDTH-1:0]
//  wr_gray_ptr  out  ADDR_WIDTH+1  registered Gray write pointer, to read domain
//  rd_gray_ptr  in   ADDR_WIDTH+1  Gray read pointer from read domain (asynchronous)
//  full         out  1             registered full flag
//  almost_full  out  1             registered, free_cnt <= AFULL_THRESH
//  free_cnt     out  ADDR_WIDTH+1  registered free entries, 0..DEPTH
//  overflow     out  1             sticky: wr_req seen while full
//  ovf_clr      in   1             clears overflow
// BEHAVIOUR
//  Reset (async): wr_bin=0, wr_gray_ptr=0, sync flops=0, full=0, free_cnt=DEPTH,
//   almost_full=(DEPTH<=AFULL_THRESH), overflow=0. wr_ready=1 out of reset.
//  Push: push = wr_req & ~full. next_bin = wr_bin + push (wraps mod 2*DEPTH);
//   next_gray = next_bin ^ (next_bin>>1). Both registered every clk.
//  wr_en/wr_addr use current (pre-increment) pointer: entry written at wr_bin, then
//   pointer advances on the same edge. No push when full, regardless of wr_req.
//  Sync: rd_gray_ptr through SYNC_STAGES flops -> rq_gray; rq_bin = gray2bin(rq_gray)
//   (rq_bin[i] = XOR of rq_gray[MSB:i]). Sync chain only; no logic before 1st flop.
//  full <= (next_gray == {~rq_gray[MSB:MSB-1], rq_gray[MSB-2:0]}) (ADDR_WIDTH>=1;
//   for ADDR_WIDTH=1 the mask covers both bits).
//  free_cnt <= DEPTH - (next_bin - rq_bin) mod 2*DEPTH; full==(free_cnt==0) always.
//  almost_full <= (DEPTH - (next_bin - rq_bin)) <= AFULL_THRESH.
//  Latency: push->full/free_cnt update 1 cycle (same edge pointer moves).
//   Read-pointer change -> flags update after SYNC_STAGES+1 clk edges. Flags are
//   conservative: stale rq_gray can only under-report free space, never over.
//  Simultaneous push and rd pointer change: both folded into same flag computation.
//  overflow: set when wr_req & full; cleared by ovf_clr; set wins if same cycle.
//  Wrap: pointer MSB toggles every DEPTH pushes; Gray changes exactly 1 bit/push.
//  Reset mid-operation: all state returns to reset values immediately; read side
//   must be reset together (shared rst_n, separately synchronized deassertion).
// TESTING
//  Params ADDR_WIDTH=3 (DEPTH=8), AFULL_THRESH=2, SYNC_STAGES=2 unless noted.
//  1 Reset: rst_n low mid-run -> full=0, free_cnt=8, almost_full=0, wr_gray_ptr=0,
//    overflow=0 asynchronously, before next clk edge.
//  2 Fill: 8 pushes, rd_gray_ptr held 0 -> wr_addr 0..7; almost_full after 6th push
//    (free_cnt=2); full=1, wr_ready=0, free_cnt=0 after 8th; wr_gray_ptr=4'b1100.
//  3 Overflow: full, wr_req=1 2 cycles -> wr_en=0, pointer unchanged, overflow=1;
//    ovf_clr & wr_req same cycle -> overflow stays 1; ovf_clr alone -> 0.
//  4 Drain sync: full, set rd_gray_ptr=4'b0001 (1 read) -> full stays 1 for 2 edges,
//    clears on 3rd edge, free_cnt=1.
//  5 Wrap: 100 push/read cycles with read following 3 behind -> wr_gray_ptr Hamming
//    distance 1 per push, free_cnt=5 steady, no full/overflow, wr_addr wraps 7->0.
//  6 Simultaneous: free_cnt=0, push attempted as rq update frees 1 -> push blocked
//    that cycle, next cycle full=0, push accepted, full re-asserts.

Source files
------------

// File: rtl/rpc2_ctrl_fifo_wr_ctrl_if.sv
// rtl/rpc2_ctrl_fifo_wr_ctrl_if.sv - push/flag signal bundle of the async FIFO write controller
interface rpc2_ctrl_fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  wr_req;
  logic                  wr_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   wr_gray_ptr;
  logic [ADDR_WIDTH:0]   rd_gray_ptr;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   free_cnt;
  logic                  overflow;
  logic                  ovf_clr;

  modport slave (
    input  wr_req, rd_gray_ptr, ovf_clr,
    output wr_ready, wr_en, wr_addr, wr_gray_ptr, full, almost_full, free_cnt, overflow
  );

  modport master (
    output wr_req, rd_gray_ptr, ovf_clr,
    input  wr_ready, wr_en, wr_addr, wr_gray_ptr, full, almost_full, free_cnt, overflow
  );
endinterface

// File: rtl/rpc2_ctrl_fifo_wr_ctrl.sv
// rtl/rpc2_ctrl_fifo_wr_ctrl.sv - write-side pointer and flag controller for async FIFOs
module rpc2_ctrl_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int AFULL_THRESH = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  rpc2_ctrl_fifo_wr_ctrl_if.slave     bus
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_V   = PW'(DEPTH);
  // Full when write pointer equals read pointer with its two top Gray bits inverted
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
  localparam logic          AFULL_RST = (DEPTH <= AFULL_THRESH);

  logic [PW-1:0] wr_bin_q;
  logic [PW-1:0] wr_gray_q;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic          full_q;
  logic          afull_q;
  logic [PW-1:0] free_q;
  logic          ovf_q;

  logic          push;
  logic [PW-1:0] next_bin;
  logic [PW-1:0] next_gray;
  logic [PW-1:0] rq_gray;
  logic [PW-1:0] rq_bin;
  logic [PW-1:0] used_nxt;
  logic [PW-1:0] free_nxt;
  logic          full_nxt;
  logic          afull_nxt;

  assign push      = bus.wr_req & ~full_q;
  assign next_bin  = wr_bin_q + PW'(push);
  assign next_gray = next_bin ^ (next_bin >> 1);
  assign rq_gray   = sync_q[SYNC_STAGES-1];

  always_comb begin
    rq_bin = '0;
    for (int i = 0; i < PW; i++) begin
      rq_bin[i] = ^(rq_gray >> i);
    end
  end

  // Modular subtraction keeps occupancy correct across pointer wrap
  assign used_nxt  = next_bin - rq_bin;
  assign free_nxt  = DEPTH_V - used_nxt;
  assign full_nxt  = (next_gray == (rq_gray ^ FULL_MASK));
  assign afull_nxt = (32'(free_nxt) <= 32'(AFULL_THRESH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.rd_gray_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      full_q    <= 1'b0;
      afull_q   <= AFULL_RST;
      free_q    <= DEPTH_V;
      ovf_q     <= 1'b0;
    end else begin
      wr_bin_q  <= next_bin;
      wr_gray_q <= next_gray;
      full_q    <= full_nxt;
      afull_q   <= afull_nxt;
      free_q    <= free_nxt;
      // A rejected request in the same cycle as a clear keeps the flag set
      if (bus.wr_req && full_q) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.wr_ready    = ~full_q;
  assign bus.wr_en       = push;
  assign bus.wr_addr     = wr_bin_q[ADDR_WIDTH-1:0];
  assign bus.wr_gray_ptr = wr_gray_q;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.free_cnt    = free_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_rpc2_ctrl_fifo_wr_ctrl.sv
// tb/tb_rpc2_ctrl_fifo_wr_ctrl.sv - randomized and directed bench for the FIFO write controller
module tb_rpc2_ctrl_fifo_wr_ctrl;

  localparam int AW    = 3;
  localparam int TH    = 2;
  localparam int SS    = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rpc2_ctrl_fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  rpc2_ctrl_fifo_wr_ctrl #(
    .ADDR_WIDTH  (AW),
    .AFULL_THRESH(TH),
    .SYNC_STAGES (SS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: total writes and reads as plain counts; the reader's
  // count reaches the write side only after SS clock edges.
  int wcnt;
  int rcnt;
  int hist[$];
  bit m_full;
  bit m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] gray(input int c);
    logic [3:0] p;
    p = 4'(c % 16);
    return p ^ (p >> 1);
  endfunction

  task automatic model_reset();
    wcnt = 0;
    rcnt = 0;
    hist = {};
    for (int i = 0; i < SS; i++) hist.push_back(0);
    m_full = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic cycle(input bit req, input bit clr);
    int  rq;
    int  used;
    bit  push;
    @(negedge clk);
    bus.wr_req      = req;
    bus.ovf_clr     = clr;
    bus.rd_gray_ptr = gray(rcnt);
    #1;
    push = req && !m_full;
    check("wr_en", 32'(bus.wr_en), 32'(push));
    check("wr_addr", 32'(bus.wr_addr), 32'(wcnt % DEPTH));
    check("wr_ready", 32'(bus.wr_ready), 32'(!m_full));
    @(posedge clk);
    #1;
    if (req && m_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    wcnt += int'(push);
    rq = hist.pop_front();
    hist.push_back(rcnt);
    used   = wcnt - rq;
    m_full = (used == DEPTH);
    check("free_cnt", 32'(bus.free_cnt), 32'(DEPTH - used));
    check("full", 32'(bus.full), 32'(m_full));
    check("almost_full", 32'(bus.almost_full), 32'((DEPTH - used) <= TH));
    check("wr_gray_ptr", 32'(bus.wr_gray_ptr), 32'(gray(wcnt)));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_free", 32'(bus.free_cnt), 32'd8);
    check("rst_afull", 32'(bus.almost_full), 32'd0);
    check("rst_gray", 32'(bus.wr_gray_ptr), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_ready", 32'(bus.wr_ready), 32'd1);
    bus.wr_req      = 1'b0;
    bus.ovf_clr     = 1'b0;
    bus.rd_gray_ptr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] prev_gray;
    rst_n           = 1'b0;
    bus.wr_req      = 1'b0;
    bus.ovf_clr     = 1'b0;
    bus.rd_gray_ptr = '0;
    model_reset();
    #12;
    check("init_free", 32'(bus.free_cnt), 32'd8);
    check("init_full", 32'(bus.full), 32'd0);
    check("init_ready", 32'(bus.wr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic: pushes and reads with varying pressure
    for (int i = 0; i < 400; i++) begin
      bit req;
      req = ($urandom_range(0, 3) != 0);
      if (i % 100 < 50) begin
        if ($urandom_range(0, 3) == 0 && rcnt < wcnt) rcnt++;
      end else begin
        if ($urandom_range(0, 1) == 0 && rcnt < wcnt) rcnt++;
      end
      cycle(req, ($urandom_range(0, 15) == 0));
    end

    mid_reset();

    // Fill with reader idle
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b0);
      if (i == 6) begin
        check("fill6_free", 32'(bus.free_cnt), 32'd2);
        check("fill6_afull", 32'(bus.almost_full), 32'd1);
      end
    end
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_ready", 32'(bus.wr_ready), 32'd0);
    check("fill_free", 32'(bus.free_cnt), 32'd0);
    check("fill_gray", 32'(bus.wr_gray_ptr), 32'b1100);

    // Overflow while full
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check("ovf_gray", 32'(bus.wr_gray_ptr), 32'b1100);
    cycle(1'b1, 1'b1);
    check("ovf_setwins", 32'(bus.overflow), 32'd1);
    cycle(1'b0, 1'b1);
    check("ovf_clr", 32'(bus.overflow), 32'd0);

    // One read becomes visible on the third edge
    rcnt = 1;
    cycle(1'b0, 1'b0);
    check("drain_e1", 32'(bus.full), 32'd1);
    cycle(1'b0, 1'b0);
    check("drain_e2", 32'(bus.full), 32'd1);
    cycle(1'b0, 1'b0);
    check("drain_e3", 32'(bus.full), 32'd0);
    check("drain_free", 32'(bus.free_cnt), 32'd1);

    // Push blocked in the cycle the freed slot arrives, accepted the next
    cycle(1'b1, 1'b0);
    check("simul_refull", 32'(bus.full), 32'd1);
    rcnt = 2;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("simul_freed", 32'(bus.full), 32'd0);
    check("simul_gray", 32'(bus.wr_gray_ptr), 32'(gray(9)));
    cycle(1'b1, 1'b0);
    check("simul_accept", 32'(bus.wr_gray_ptr), 32'(gray(10)));
    check("simul_full", 32'(bus.full), 32'd1);
    cycle(1'b0, 1'b1);

    mid_reset();

    // Steady streaming across many pointer wraps
    for (int i = 0; i < 100; i++) begin
      prev_gray = bus.wr_gray_ptr;
      rcnt = wcnt;
      cycle(1'b1, 1'b0);
      check("wrap_hamming", 32'($countones(prev_gray ^ bus.wr_gray_ptr)), 32'd1);
      if (i >= 4) check("wrap_free", 32'(bus.free_cnt), 32'd5);
    end
    check("wrap_ovf", 32'(bus.overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
